// File: rtl/npc_ifu.sv
// npc_ifu: instruction fetch stage, one outstanding imem request,
// valid/ready hand-off of {inst, pc, fault} to decode, PC redirects.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   redirect_valid    load redirect_target (word aligned) as fetch PC
//   redirect_target   new PC, bits [1:0] ignored
//   imem_req_*        request channel (valid/ready, addr = current PC)
//   imem_rsp_*        one-cycle response pulse with data and fault
//   out_*             decode channel (valid/ready, inst, pc, fault)
module npc_ifu #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] tgt;

  assign tgt = {redirect_target[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      opc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_d         = drop_q;
    inst_d         = inst_q;
    opc_d          = opc_q;
    fault_d        = fault_q;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    unique case (state_q)
      REQ: begin
        imem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_d = tgt;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d   = tgt;
          drop_d = 1'b1;
        end
        if (imem_rsp_valid) begin
          // A redirect landing with the response also kills it.
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d  = imem_rsp_data;
            opc_d   = pc_q;
            fault_d = imem_rsp_err;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  assign imem_req_addr = pc_q;
  assign out_inst      = inst_q;
  assign out_pc        = opc_q;
  assign out_fault     = fault_q;

endmodule

// File: tb/tb_npc_ifu.sv
// tb_npc_ifu: directed and randomized checks of npc_ifu against a
// transaction-level model (busy/stale/held flags) and literal values.
module tb_npc_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  int total = 0;
  int bad = 0;

  int ready_pct = 100;
  int lat = 0;
  int lat_rand = 0;
  int err_pct = 0;
  int spur_pct = 0;
  logic [31:0] err_addr = 32'h1;

  npc_ifu #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0050_0093;
    if (a == 32'h8000_0004) return 32'h0010_8113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // memory: accepts a request, answers after lat cycles
  initial begin
    logic        acc, seen, r, pending;
    logic [31:0] a, paddr;
    int          cnt;
    pending = 1'b0;
    paddr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      acc  = imem_req_valid && imem_req_ready && !rst;
      a    = imem_req_addr;
      seen = imem_rsp_valid;
      r    = rst;
      @(posedge clk);
      #2;
      if (r || seen) pending = 1'b0;
      if (acc) begin
        pending = 1'b1;
        paddr = a;
        cnt = (lat_rand != 0) ? int'($urandom_range(0, 2)) : lat;
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_err = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data = memf(paddr);
          imem_rsp_err = (paddr == err_addr) ||
                         (int'($urandom_range(0, 99)) < err_pct);
        end else begin
          cnt--;
        end
      end else if (int'($urandom_range(0, 99)) < spur_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = $urandom;
        imem_rsp_err = 1'($urandom_range(0, 1));
      end
      imem_req_ready = int'($urandom_range(0, 99)) < ready_pct;
    end
  end

  // reference model and per-cycle comparison
  initial begin
    logic [31:0] m_pc, m_inst, m_opc;
    logic        m_busy, m_stale, m_held, m_fault;
    logic        s_rst, s_redir, s_rdy, s_rsp, s_err, s_ordy;
    logic [31:0] s_tgt, s_data;
    logic        e_rv;
    @(posedge clk);
    m_pc = 32'h8000_0000;
    {m_busy, m_stale, m_held, m_fault} = '0;
    m_inst = '0;
    m_opc = '0;
    forever begin
      @(negedge clk);
      s_rst   = rst;
      s_redir = redirect_valid;
      s_tgt   = {redirect_target[31:2], 2'b00};
      s_rdy   = imem_req_ready;
      s_rsp   = imem_rsp_valid;
      s_data  = imem_rsp_data;
      s_err   = imem_rsp_err;
      s_ordy  = out_ready;
      e_rv = !m_held && !m_busy && !s_redir;
      chk("m_req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) chk("m_req_addr", imem_req_addr, m_pc);
      chk("m_out_valid", 32'(out_valid), 32'(m_held));
      chk("m_out_inst", out_inst, m_inst);
      chk("m_out_pc", out_pc, m_opc);
      chk("m_out_fault", 32'(out_fault), 32'(m_fault));
      @(posedge clk);
      if (s_rst) begin
        m_pc = 32'h8000_0000;
        {m_busy, m_stale, m_held, m_fault} = '0;
        m_inst = '0;
        m_opc = '0;
      end else if (m_held) begin
        if (s_redir) begin
          m_pc = s_tgt;
          m_held = 1'b0;
        end else if (s_ordy) begin
          m_pc = m_pc + 32'd4;
          m_held = 1'b0;
        end
      end else if (m_busy) begin
        if (s_rsp) begin
          m_busy = 1'b0;
          if (m_stale || s_redir) begin
            m_stale = 1'b0;
          end else begin
            m_held = 1'b1;
            m_inst = s_data;
            m_opc = m_pc;
            m_fault = s_err;
          end
        end else if (s_redir) begin
          m_stale = 1'b1;
        end
        if (s_redir) m_pc = s_tgt;
      end else begin
        if (s_redir) m_pc = s_tgt;
        else if (s_rdy) m_busy = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid timeout got=0 want=1 t=%0t", $time);
    end
  endtask

  initial begin
    int   n;
    logic seen;

    // A: reset state, zero-wait back-to-back fetch
    out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    wait_valid(n);
    chk("a_lat", 32'(n), 32'd2);
    chk("a_pc0", out_pc, 32'h8000_0000);
    chk("a_inst0", out_inst, 32'h0050_0093);
    wait_valid(n);
    chk("a_gap", 32'(n), 32'd3);
    chk("a_pc1", out_pc, 32'h8000_0004);
    chk("a_inst1", out_inst, 32'h0010_8113);

    // B: backpressure in HOLD
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_valid", 32'(out_valid), 32'd1);
      chk("b_pc", out_pc, 32'h8000_0000);
      chk("b_inst", out_inst, 32'h0050_0093);
      chk("b_req_valid", 32'(imem_req_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b_rel_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("b_next_rv", 32'(imem_req_valid), 32'd1);
    chk("b_next_addr", imem_req_addr, 32'h8000_0004);

    // C: redirect during WAIT drops the late response
    lat = 3;
    do_reset();
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0102;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1'b1;
    end while (!imem_req_valid && n < 20);
    chk("c_no_out", 32'(seen), 32'd0);
    chk("c_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c_req_addr", imem_req_addr, 32'h8000_0100);
    wait_valid(n);
    chk("c_out_pc", out_pc, 32'h8000_0100);
    chk("c_out_inst", out_inst, memf(32'h8000_0100));

    // D: redirect together with handshake in HOLD
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    wait_valid(n);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0200;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("d_req_valid", 32'(imem_req_valid), 32'd1);
    chk("d_req_addr", imem_req_addr, 32'h8000_0200);

    // E: request stalled by memory, redirect in REQ
    ready_pct = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("e_rv", 32'(imem_req_valid), 32'd1);
      chk("e_addr", imem_req_addr, 32'h8000_0000);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0010;
    ready_pct = 100;
    @(negedge clk);
    chk("e_rv_redir", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("e_rv_after", 32'(imem_req_valid), 32'd1);
    chk("e_addr_after", imem_req_addr, 32'h8000_0010);

    // F: access fault pass-through, reset while in WAIT
    err_addr = 32'h8000_0008;
    do_reset();
    @(negedge clk);
    wait_valid(n);
    chk("f_fault0", 32'(out_fault), 32'd0);
    wait_valid(n);
    wait_valid(n);
    chk("f_pc", out_pc, 32'h8000_0008);
    chk("f_fault", 32'(out_fault), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("f_rst_rv", 32'(imem_req_valid), 32'd1);
    chk("f_rst_addr", imem_req_addr, 32'h8000_0000);
    chk("f_rst_ov", 32'(out_valid), 32'd0);
    chk("f_rst_fault", 32'(out_fault), 32'd0);
    err_addr = 32'h1;

    // random traffic against the model
    lat_rand = 1;
    ready_pct = 70;
    err_pct = 15;
    spur_pct = 5;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        redirect_target = 32'h8000_0000 + 32'($urandom_range(0, 1023));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
